// File: rtl/rtl_mch_cnt_pkg.sv
// ============================================================================
// rtl_mch_cnt_pkg : shared add-mode encoding and sizing helper for rtl_mch_cnt
// Revision 1.0
// ============================================================================
`default_nettype none

package rtl_mch_cnt_pkg;

    typedef enum logic {
        ADD_WRAP = 1'b0,
        ADD_SAT  = 1'b1
    } add_mode_e;

    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

    function automatic int clog2(input int value);
        int r;
        for (r = 0; (1 << r) < value; r++) begin
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rtl_sat_add.sv
// ============================================================================
// rtl_sat_add : counter + increment adder, saturating or wrapping, with carry
// Revision 1.0
// ============================================================================
`default_nettype none

module rtl_sat_add
    import rtl_mch_cnt_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int INCW  = 9
) (
    input  logic [WIDTH-1:0] a,
    input  logic [INCW-1:0]  b,
    input  add_mode_e        mode,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);

    logic [WIDTH:0] full;

    assign full  = {1'b0, a} + (WIDTH+1)'(b);
    assign carry = full[WIDTH];
    // An all-ones counter plus any nonzero increment carries, so it stays pinned.
    assign sum   = (mode == ADD_SAT && carry) ? {WIDTH{1'b1}} : full[WIDTH-1:0];

endmodule

`default_nettype wire

// File: rtl/rtl_mch_cnt.sv
// ============================================================================
// rtl_mch_cnt : multi-channel event/byte counter bank with RO / read-to-clear CPU port
// Revision 1.0
// ============================================================================
`default_nettype none

module rtl_mch_cnt
    import rtl_mch_cnt_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int NUM   = 8,
    parameter int CHN   = 16,
    parameter int CHW   = 4,
    parameter int SAT   = 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             vld,
    input  logic [CHW-1:0]   chid,
    input  logic [NUM-1:0]   num,
    input  logic             upen_ro,
    input  logic             upen_r2c,
    input  logic [CHW-1:0]   upaddr,
    input  logic             uprs,
    output logic             uprdy,
    output logic [WIDTH-1:0] updo,
    output logic [CHN-1:0]   ovf
);

    localparam add_mode_e MODE = (SAT == MODE_SAT) ? ADD_SAT : ADD_WRAP;

    generate
        if (clog2(CHN) > CHW) begin : g_chw_check
            $error("rtl_mch_cnt: CHW too narrow for CHN channels");
        end
    endgenerate

    logic             s1_vld;
    logic [CHW-1:0]   s1_chid;
    logic [NUM:0]     s1_inc;

    logic [WIDTH-1:0] cnt [CHN];
    logic [CHN-1:0]   ovf_q;

    logic             chid_ok;
    logic             rd_acc;
    logic [WIDTH-1:0] cur;
    logic [WIDTH-1:0] rd_mux;
    logic [CHN-1:0]   s2_hit;
    logic [CHN-1:0]   clr_hit;
    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_sum;
    logic             add_carry;

    logic             rd_v;
    logic [WIDTH-1:0] rd_d;

    // Out-of-range ids and addresses match no channel, so they drop / read as zero.
    always_comb begin
        chid_ok = 1'b0;
        cur     = '0;
        rd_mux  = '0;
        s2_hit  = '0;
        clr_hit = '0;
        rd_acc  = uprs & (upen_ro | upen_r2c);
        for (int i = 0; i < CHN; i++) begin
            if (chid == CHW'(i))    chid_ok = 1'b1;
            if (s1_chid == CHW'(i)) cur     = cnt[i];
            if (upaddr == CHW'(i))  rd_mux  = cnt[i];
            s2_hit[i]  = s1_vld && (s1_chid == CHW'(i));
            clr_hit[i] = rd_acc && upen_r2c && (upaddr == CHW'(i));
        end
        // A clear colliding with an update restarts the count from the increment.
        add_a = (|(s2_hit & clr_hit)) ? '0 : cur;
    end

    rtl_sat_add #(
        .WIDTH (WIDTH),
        .INCW  (NUM + 1)
    ) u_add (
        .a     (add_a),
        .b     (s1_inc),
        .mode  (MODE),
        .sum   (add_sum),
        .carry (add_carry)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_vld  <= 1'b0;
            s1_chid <= '0;
            s1_inc  <= '0;
        end else begin
            s1_vld  <= vld & chid_ok;
            s1_chid <= chid;
            s1_inc  <= (NUM+1)'(num) + (NUM+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < CHN; i++) begin
                cnt[i] <= '0;
            end
            ovf_q <= '0;
        end else begin
            for (int i = 0; i < CHN; i++) begin
                if (s2_hit[i]) begin
                    cnt[i]   <= add_sum;
                    ovf_q[i] <= (ovf_q[i] & ~clr_hit[i]) | add_carry;
                end else if (clr_hit[i]) begin
                    cnt[i]   <= '0;
                    ovf_q[i] <= 1'b0;
                end
            end
        end
    end

    // Read data is captured pre-update at the accepting edge, presented one edge later.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_v  <= 1'b0;
            rd_d  <= '0;
            uprdy <= 1'b0;
            updo  <= '0;
        end else begin
            rd_v  <= rd_acc;
            rd_d  <= rd_acc ? rd_mux : '0;
            uprdy <= rd_v;
            updo  <= rd_v ? rd_d : '0;
        end
    end

    assign ovf = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_rtl_mch_cnt.sv
// ============================================================================
// tb_rtl_mch_cnt : four configurations of rtl_mch_cnt against a behavioural model
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_rtl_mch_cnt;

    logic       clk = 1'b0;
    logic       rstn = 1'b1;
    logic       vld = 1'b0;
    logic [3:0] chid = '0;
    logic [7:0] num = '0;
    logic       upen_ro = 1'b0;
    logic       upen_r2c = 1'b0;
    logic [3:0] upaddr = '0;
    logic       uprs = 1'b0;

    always #5 clk = ~clk;

    logic        uprdy_a, uprdy_b, uprdy_c, uprdy_d;
    logic [31:0] updo_a, updo_d;
    logic [7:0]  updo_b, updo_c;
    logic [15:0] ovf_a, ovf_b, ovf_c;
    logic [11:0] ovf_d;

    // a: 32-bit saturating, b: 8-bit saturating, c: 8-bit wrapping, d: 12 channels
    rtl_mch_cnt #(.WIDTH(32), .NUM(8), .CHN(16), .CHW(4), .SAT(1)) dut_a (
        .clk(clk), .rstn(rstn), .vld(vld), .chid(chid), .num(num),
        .upen_ro(upen_ro), .upen_r2c(upen_r2c), .upaddr(upaddr), .uprs(uprs),
        .uprdy(uprdy_a), .updo(updo_a), .ovf(ovf_a));
    rtl_mch_cnt #(.WIDTH(8), .NUM(8), .CHN(16), .CHW(4), .SAT(1)) dut_b (
        .clk(clk), .rstn(rstn), .vld(vld), .chid(chid), .num(num),
        .upen_ro(upen_ro), .upen_r2c(upen_r2c), .upaddr(upaddr), .uprs(uprs),
        .uprdy(uprdy_b), .updo(updo_b), .ovf(ovf_b));
    rtl_mch_cnt #(.WIDTH(8), .NUM(8), .CHN(16), .CHW(4), .SAT(0)) dut_c (
        .clk(clk), .rstn(rstn), .vld(vld), .chid(chid), .num(num),
        .upen_ro(upen_ro), .upen_r2c(upen_r2c), .upaddr(upaddr), .uprs(uprs),
        .uprdy(uprdy_c), .updo(updo_c), .ovf(ovf_c));
    rtl_mch_cnt #(.WIDTH(32), .NUM(8), .CHN(12), .CHW(4), .SAT(1)) dut_d (
        .clk(clk), .rstn(rstn), .vld(vld), .chid(chid), .num(num),
        .upen_ro(upen_ro), .upen_r2c(upen_r2c), .upaddr(upaddr), .uprs(uprs),
        .uprdy(uprdy_d), .updo(updo_d), .ovf(ovf_d));

    logic        uprdy_w [4];
    logic [31:0] updo_w  [4];
    logic [15:0] ovf_w   [4];

    always_comb begin
        uprdy_w[0] = uprdy_a;
        uprdy_w[1] = uprdy_b;
        uprdy_w[2] = uprdy_c;
        uprdy_w[3] = uprdy_d;
        updo_w[0]  = updo_a;
        updo_w[1]  = {24'd0, updo_b};
        updo_w[2]  = {24'd0, updo_c};
        updo_w[3]  = updo_d;
        ovf_w[0]   = ovf_a;
        ovf_w[1]   = ovf_b;
        ovf_w[2]   = ovf_c;
        ovf_w[3]   = {4'd0, ovf_d};
    end

    int total = 0;
    int bad   = 0;
    int pulses = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int     wp  [4] = '{32, 8, 8, 32};
    int     satp[4] = '{1, 1, 0, 1};
    int     chn [4] = '{16, 16, 16, 12};

    longint mcnt [4][16];
    bit     movf [4][16];
    bit     pv   [4];
    int     pch  [4];
    longint pinc [4];

    typedef struct {
        int     due;
        longint data;
    } rd_t;
    rd_t    rq [4][$];
    int     cyc = 0;

    // Events become visible one edge after capture; reads see the pre-update value.
    always @(posedge clk or negedge rstn) begin
        rd_t    e;
        longint mx;
        longint s;
        if (!rstn) begin
            for (int d = 0; d < 4; d++) begin
                for (int c = 0; c < 16; c++) begin
                    mcnt[d][c] = 0;
                    movf[d][c] = 1'b0;
                end
                pv[d] = 1'b0;
                rq[d].delete();
            end
        end else begin
            cyc++;
            for (int d = 0; d < 4; d++) begin
                mx = (longint'(1) << wp[d]) - 1;
                if (uprs && (upen_ro || upen_r2c)) begin
                    e.due  = cyc + 1;
                    e.data = (int'(upaddr) < chn[d]) ? mcnt[d][upaddr] : 0;
                    rq[d].push_back(e);
                    if (upen_r2c && int'(upaddr) < chn[d]) begin
                        mcnt[d][upaddr] = 0;
                        movf[d][upaddr] = 1'b0;
                    end
                end
                if (pv[d]) begin
                    s = mcnt[d][pch[d]] + pinc[d];
                    if (s > mx) begin
                        movf[d][pch[d]] = 1'b1;
                        mcnt[d][pch[d]] = (satp[d] != 0) ? mx : (s & mx);
                    end else begin
                        mcnt[d][pch[d]] = s;
                    end
                end
                pv[d]   = vld && (int'(chid) < chn[d]);
                pch[d]  = int'(chid);
                pinc[d] = longint'(num) + 1;
            end
        end
    end

    always @(negedge clk) begin
        bit          ev;
        longint      ed;
        logic [15:0] eo;
        for (int d = 0; d < 4; d++) begin
            ev = (rq[d].size() > 0) && (rq[d][0].due == cyc);
            ed = ev ? rq[d][0].data : 0;
            eo = '0;
            for (int c = 0; c < 16; c++) begin
                if (c < chn[d]) eo[c] = movf[d][c];
            end
            chk($sformatf("uprdy[%0d]", d), {63'd0, uprdy_w[d]}, {63'd0, ev});
            chk($sformatf("updo[%0d]", d), {32'd0, updo_w[d]}, ed);
            chk($sformatf("ovf[%0d]", d), {48'd0, ovf_w[d]}, {48'd0, eo});
            while (rq[d].size() > 0 && rq[d][0].due <= cyc) void'(rq[d].pop_front());
        end
        if (uprdy_w[0]) pulses++;
    end

    // ---------------- stimulus ----------------
    logic [31:0] rd_val [4];
    logic        rd_rdy [4];

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic idle();
        vld = 1'b0; uprs = 1'b0; upen_ro = 1'b0; upen_r2c = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        #2 rstn = 1'b0;
        step(2);
        rstn = 1'b1;
        step(1);
    endtask

    task automatic issue_read(input logic [3:0] a, input bit r2c);
        bit got;
        upaddr = a; uprs = 1'b1; upen_ro = ~r2c; upen_r2c = r2c;
        @(negedge clk);
        uprs = 1'b0; upen_ro = 1'b0; upen_r2c = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 4 && !got; k++) begin
            @(negedge clk);
            if (uprdy_w[0]) got = 1'b1;
        end
        chk("rd_timeout", {63'd0, got}, 64'd1);
        for (int d = 0; d < 4; d++) begin
            rd_val[d] = updo_w[d];
            rd_rdy[d] = uprdy_w[d];
        end
    endtask

    initial begin
        #1 rstn = 1'b0;
        step(2);
        rstn = 1'b1;
        chk("rst_uprdy", {63'd0, uprdy_a}, 64'd0);
        chk("rst_updo", {32'd0, updo_a}, 64'd0);
        chk("rst_ovf", {48'd0, ovf_a}, 64'd0);
        step(1);

        // 1: three events of 5 on ch3
        chid = 4'd3; num = 8'd4; vld = 1'b1;
        step(3);
        vld = 1'b0;
        step(2);
        issue_read(4'd3, 1'b0);
        chk("t1_ch3", {32'd0, rd_val[0]}, 64'd15);
        step(1);
        chk("t1_one_pulse", {63'd0, uprdy_w[0]}, 64'd0);
        issue_read(4'd4, 1'b0);
        chk("t1_ch4", {32'd0, rd_val[0]}, 64'd0);

        // 2: 300 unit events on ch1, saturate vs wrap at 8 bits
        do_reset();
        chid = 4'd1; num = 8'd0; vld = 1'b1;
        step(300);
        vld = 1'b0;
        step(2);
        issue_read(4'd1, 1'b0);
        chk("t2_sat8", {32'd0, rd_val[1]}, 64'd255);
        chk("t2_wrap8", {32'd0, rd_val[2]}, 64'd44);
        chk("t2_w32", {32'd0, rd_val[0]}, 64'd300);
        chk("t2_ovf_sat", {63'd0, ovf_w[1][1]}, 64'd1);
        chk("t2_ovf_wrap", {63'd0, ovf_w[2][1]}, 64'd1);
        chk("t2_ovf_w32", {63'd0, ovf_w[0][1]}, 64'd0);

        // 3: read-to-clear colliding with an update on the same channel
        do_reset();
        chid = 4'd5; num = 8'd9; vld = 1'b1;
        step(2);
        vld = 1'b0;
        step(2);
        chid = 4'd5; num = 8'd1; vld = 1'b1;
        step(1);
        vld = 1'b0;
        issue_read(4'd5, 1'b1);
        chk("t3_old", {32'd0, rd_val[0]}, 64'd20);
        issue_read(4'd5, 1'b0);
        chk("t3_new", {32'd0, rd_val[0]}, 64'd2);
        chk("t3_ovf5", {63'd0, ovf_w[0][5]}, 64'd0);
        // colliding increment of 256 overflows an 8-bit counter even from zero
        chid = 4'd6; num = 8'd255; vld = 1'b1;
        step(1);
        vld = 1'b0;
        step(2);
        chid = 4'd6; num = 8'd255; vld = 1'b1;
        step(1);
        vld = 1'b0;
        issue_read(4'd6, 1'b1);
        chk("t3_old6_sat", {32'd0, rd_val[1]}, 64'd255);
        issue_read(4'd6, 1'b0);
        chk("t3_new6_sat", {32'd0, rd_val[1]}, 64'd255);
        chk("t3_new6_wrap", {32'd0, rd_val[2]}, 64'd0);
        chk("t3_new6_w32", {32'd0, rd_val[0]}, 64'd256);
        chk("t3_ovf6_sat", {63'd0, ovf_w[1][6]}, 64'd1);
        chk("t3_ovf6_w32", {63'd0, ovf_w[0][6]}, 64'd0);

        // 4: back-to-back reads of all channels, alternating ro / r2c
        do_reset();
        for (int i = 0; i < 16; i++) begin
            chid = 4'(i); num = 8'(i); vld = 1'b1;
            step(1);
        end
        vld = 1'b0;
        step(2);
        pulses = 0;
        for (int i = 0; i < 16; i++) begin
            upaddr = 4'(i); uprs = 1'b1;
            upen_ro = ~i[0]; upen_r2c = i[0];
            step(1);
        end
        idle();
        step(4);
        chk("t4_pulses", 64'(pulses), 64'd16);
        issue_read(4'd1, 1'b0);
        chk("t4_ch1_cleared", {32'd0, rd_val[0]}, 64'd0);
        issue_read(4'd2, 1'b0);
        chk("t4_ch2_kept", {32'd0, rd_val[0]}, 64'd3);

        // 5: reset during an event burst with a read in flight
        do_reset();
        chid = 4'd2; num = 8'd7; vld = 1'b1;
        step(2);
        upaddr = 4'd2; uprs = 1'b1; upen_ro = 1'b1;
        @(posedge clk);
        #2 rstn = 1'b0;
        @(negedge clk);
        idle();
        pulses = 0;
        step(2);
        rstn = 1'b1;
        step(4);
        chk("t5_no_pulse", 64'(pulses), 64'd0);
        chk("t5_ovf", {48'd0, ovf_w[0]}, 64'd0);
        issue_read(4'd2, 1'b0);
        chk("t5_ch2", {32'd0, rd_val[0]}, 64'd0);

        // 6: ids beyond CHN on the 12-channel bank
        do_reset();
        chid = 4'd15; num = 8'd3; vld = 1'b1;
        step(1);
        vld = 1'b0;
        step(2);
        issue_read(4'd14, 1'b0);
        chk("t6_rdy_d", {63'd0, rd_rdy[3]}, 64'd1);
        chk("t6_updo_d", {32'd0, rd_val[3]}, 64'd0);
        issue_read(4'd15, 1'b0);
        chk("t6_ch15_a", {32'd0, rd_val[0]}, 64'd4);
        chk("t6_ch15_d", {32'd0, rd_val[3]}, 64'd0);
        chk("t6_ovf_d", {48'd0, ovf_w[3]}, 64'd0);

        step(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
